// File: rtl/pipe_mem_arbiter.sv
// rtl/pipe_mem_arbiter.sv - Wishbone arbiter sharing one master bus between the IF and MEM pipeline ports
// Optional bus watchdog: define ARB_TIMEOUT_EN.
module pipe_mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    if_req_i,
  input  logic [ADDR_WIDTH-1:0]   if_addr_i,
  output logic                    if_ack_o,
  output logic [DATA_WIDTH-1:0]   if_rdata_o,
  output logic                    if_stall_o,
  input  logic                    mem_req_i,
  input  logic                    mem_we_i,
  input  logic [DATA_WIDTH/8-1:0] mem_sel_i,
  input  logic [ADDR_WIDTH-1:0]   mem_addr_i,
  input  logic [DATA_WIDTH-1:0]   mem_wdata_i,
  output logic                    mem_ack_o,
  output logic [DATA_WIDTH-1:0]   mem_rdata_o,
  output logic                    mem_stall_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_ack_i,
  output logic                    bus_err_o
);

  typedef enum logic [1:0] {IDLE, BUS_MEM, BUS_IF, DONE} state_t;

  state_t state_q, state_d;
  logic   start_mem, start_if, finish, timeout, in_bus;

  assign in_bus = (state_q == BUS_MEM) || (state_q == BUS_IF);

`ifdef ARB_TIMEOUT_EN
  localparam int CLOG_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W  = (CLOG_W > 8) ? CLOG_W : 8;

  logic [CNT_W-1:0] cnt_q;
  logic             bus_err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (!in_bus) begin
      cnt_q <= '0;
    end else if (!wb_ack_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Fires on the cycle the count would reach the limit; a same-cycle ack takes precedence.
  assign timeout = in_bus && !wb_ack_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) bus_err_q <= 1'b0;
    else         bus_err_q <= timeout;
  end

  assign bus_err_o = bus_err_q;
`else
  assign timeout   = 1'b0;
  assign bus_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start_mem = 1'b0;
    start_if  = 1'b0;
    finish    = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_req_i) begin
          start_mem = 1'b1;
          state_d   = BUS_MEM;
        end else if (if_req_i) begin
          start_if = 1'b1;
          state_d  = BUS_IF;
        end
      end
      BUS_MEM, BUS_IF: begin
        if (wb_ack_i || timeout) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_adr_o    <= '0;
      wb_dat_o    <= '0;
      wb_sel_o    <= '0;
      if_ack_o    <= 1'b0;
      mem_ack_o   <= 1'b0;
      if_rdata_o  <= '0;
      mem_rdata_o <= '0;
    end else begin
      if_ack_o  <= finish && (state_q == BUS_IF);
      mem_ack_o <= finish && (state_q == BUS_MEM);
      if (start_mem) begin
        wb_cyc_o <= 1'b1;
        wb_stb_o <= 1'b1;
        wb_we_o  <= mem_we_i;
        wb_adr_o <= mem_addr_i;
        wb_dat_o <= mem_wdata_i;
        wb_sel_o <= mem_sel_i;
      end else if (start_if) begin
        wb_cyc_o <= 1'b1;
        wb_stb_o <= 1'b1;
        wb_we_o  <= 1'b0;
        wb_adr_o <= if_addr_i;
        wb_sel_o <= '1;
      end else if (finish) begin
        wb_cyc_o <= 1'b0;
        wb_stb_o <= 1'b0;
      end
      // A watchdog completion returns zero instead of whatever is on the bus.
      if (finish && (state_q == BUS_MEM)) mem_rdata_o <= wb_ack_i ? wb_dat_i : '0;
      if (finish && (state_q == BUS_IF))  if_rdata_o  <= wb_ack_i ? wb_dat_i : '0;
    end
  end

  assign if_stall_o  = if_req_i & ~if_ack_o;
  assign mem_stall_o = mem_req_i & ~mem_ack_o;

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// tb/tb_pipe_mem_arbiter.sv - self-checking bench for pipe_mem_arbiter (vectors, corner sequences, random)
module tb_pipe_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_stall;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [3:0]  mem_sel = '0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel;
  logic        wb_ack;
  logic        bus_err;

  // Slave: acks on the slave_lat-th strobe cycle and returns address XOR rd_key.
  logic        slave_en = 1'b0;
  logic        force_ack = 1'b0;
  int          slave_lat = 1;
  logic [31:0] rd_key = '0;
  int          stb_cnt;

  int total = 0;
  int bad = 0;
  logic [31:0] hold_if = '0;
  logic [31:0] hold_mem = '0;

  always #5 clk = ~clk;

  assign wb_dat_i = wb_adr ^ rd_key;
  assign wb_ack   = force_ack | (slave_en & wb_cyc & wb_stb & (stb_cnt == slave_lat - 1));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          stb_cnt <= 0;
    else if (wb_cyc && wb_stb && !wb_ack) stb_cnt <= stb_cnt + 1;
    else                                 stb_cnt <= 0;
  end

  pipe_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_rdata_o(if_rdata), .if_stall_o(if_stall),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_sel_i(mem_sel), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .mem_ack_o(mem_ack), .mem_rdata_o(mem_rdata), .mem_stall_o(mem_stall),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o),
    .wb_sel_o(wb_sel), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack), .bus_err_o(bus_err)
  );

  typedef struct {
    bit          mem_req;
    bit          we;
    logic [3:0]  sel;
    logic [31:0] mem_addr;
    logic [31:0] wdata;
    bit          if_req;
    logic [31:0] if_addr;
    int          lat;
    logic [31:0] key;
    logic [31:0] exp_mem;
    logic [31:0] exp_if;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference timeline: MEM first if requested; each transaction holds cyc for lat cycles,
  // acks the cycle after, and the next one strobes two cycles after that ack.
  task automatic run_vec(input vec_t v, input string nm);
    bit   port [2];
    int   s [2];
    int   n, last, cur;
    logic ec, ema, eia;
    n = 0;
    if (v.mem_req) begin port[n] = 1'b1; n++; end
    if (v.if_req)  begin port[n] = 1'b0; n++; end
    for (int j = 0; j < n; j++) s[j] = 1 + j * (v.lat + 2);
    last = s[n-1] + v.lat;
    slave_en = 1'b1; slave_lat = v.lat; rd_key = v.key;
    mem_req = v.mem_req; mem_we = v.we; mem_sel = v.sel; mem_addr = v.mem_addr; mem_wdata = v.wdata;
    if_req = v.if_req; if_addr = v.if_addr;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      ec = 1'b0; ema = 1'b0; eia = 1'b0; cur = 0;
      for (int j = 0; j < n; j++) begin
        if (c >= s[j] && c < s[j] + v.lat) begin ec = 1'b1; cur = j; end
        if (c == s[j] + v.lat) begin
          if (port[j]) ema = 1'b1;
          else         eia = 1'b1;
        end
      end
      chk({nm, ".cyc"}, wb_cyc, ec);
      chk({nm, ".stb"}, wb_stb, ec);
      chk({nm, ".mem_ack"}, mem_ack, ema);
      chk({nm, ".if_ack"}, if_ack, eia);
      chk({nm, ".mem_stall"}, mem_stall, mem_req & ~ema);
      chk({nm, ".if_stall"}, if_stall, if_req & ~eia);
      chk({nm, ".bus_err"}, bus_err, 1'b0);
      if (ec) begin
        if (port[cur]) begin
          chk({nm, ".adr_mem"}, wb_adr, v.mem_addr);
          chk({nm, ".we_mem"}, wb_we, v.we);
          chk({nm, ".sel_mem"}, wb_sel, v.sel);
          if (v.we) chk({nm, ".dat_mem"}, wb_dat_o, v.wdata);
        end else begin
          chk({nm, ".adr_if"}, wb_adr, v.if_addr);
          chk({nm, ".we_if"}, wb_we, 1'b0);
          chk({nm, ".sel_if"}, wb_sel, 4'hf);
        end
      end
      if (ema) begin chk({nm, ".mem_rdata"}, mem_rdata, v.exp_mem); hold_mem = v.exp_mem; end
      if (eia) begin chk({nm, ".if_rdata"}, if_rdata, v.exp_if); hold_if = v.exp_if; end
      @(posedge clk); #1;
      if (ema) mem_req = 1'b0;
      if (eia) if_req = 1'b0;
    end
    @(negedge clk);
    chk({nm, ".idle_cyc"}, wb_cyc, 1'b0);
    chk({nm, ".idle_acks"}, {mem_ack, if_ack}, 2'b00);
    chk({nm, ".hold_mem"}, mem_rdata, hold_mem);
    chk({nm, ".hold_if"}, if_rdata, hold_if);
    @(posedge clk); #1;
  endtask

  vec_t tbl [5];
  vec_t r;
  int   acks, rises;
  logic prev_cyc;

  initial begin
    //        mem  we  sel    mem_addr       wdata          if   if_addr        lat key            exp_mem        exp_if
    tbl[0] = '{1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 32'h8000_0000, 2, 32'h8010_0093, 32'h0,        32'h0010_0093};
    tbl[1] = '{1'b1, 1'b0, 4'hf, 32'h8040_0000, 32'h0,        1'b1, 32'h8000_0004, 1, 32'h1234_5678, 32'h9274_5678, 32'h9234_567C};
    tbl[2] = '{1'b1, 1'b1, 4'h3, 32'h8040_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,        3, 32'h0,        32'h8040_0010, 32'h0};
    tbl[3] = '{1'b1, 1'b1, 4'hc, 32'h0000_0100, 32'h0BAD_F00D, 1'b1, 32'h0000_0200, 4, 32'hFFFF_FFFF, 32'hFFFF_FEFF, 32'hFFFF_FDFF};
    tbl[4] = '{1'b1, 1'b0, 4'h5, 32'h1000_0000, 32'h0,        1'b0, 32'h0,        1, 32'h0000_00FF, 32'h1000_00FF, 32'h0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.cyc_stb_we", {wb_cyc, wb_stb, wb_we}, 3'b000);
    chk("rst.adr", wb_adr, 32'h0);
    chk("rst.dat", wb_dat_o, 32'h0);
    chk("rst.sel", wb_sel, 4'h0);
    chk("rst.acks_err", {if_ack, mem_ack, bus_err}, 3'b000);
    chk("rst.if_rdata", if_rdata, 32'h0);
    chk("rst.mem_rdata", mem_rdata, 32'h0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst.cyc", wb_cyc, 1'b0);
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Reset while fetch is on the bus, then a stray ack after release.
    slave_en = 1'b0; if_req = 1'b1; if_addr = 32'h8000_0040; rd_key = 32'h0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst.cyc_before", wb_cyc, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.cyc_async", wb_cyc, 1'b0);
    chk("midrst.stb_async", wb_stb, 1'b0);
    @(posedge clk); #1;
    if_req = 1'b0; rst_n = 1'b1; force_ack = 1'b1;
    @(negedge clk);
    chk("midrst.cyc_after", wb_cyc, 1'b0);
    @(posedge clk); #1;
    force_ack = 1'b0;
    @(negedge clk);
    chk("midrst.no_if_ack", if_ack, 1'b0);
    chk("midrst.no_mem_ack", mem_ack, 1'b0);
    chk("midrst.if_rdata", if_rdata, 32'h0);
    hold_if = 32'h0; hold_mem = 32'h0;
    @(posedge clk); #1;

    // Fetch request held continuously across three transactions.
    slave_en = 1'b1; slave_lat = 1; rd_key = 32'h0F0F_0F0F; if_addr = 32'h8000_0100; if_req = 1'b1;
    acks = 0; rises = 0; prev_cyc = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      if (if_ack) begin
        acks++;
        chk("b2b.rdata", if_rdata, 32'h8F0F_0E0F);
      end
      if (wb_cyc && !prev_cyc) rises++;
      prev_cyc = wb_cyc;
      chk("b2b.no_mem_ack", mem_ack, 1'b0);
      @(posedge clk); #1;
      if (c == 8) if_req = 1'b0;
    end
    chk("b2b.ack_count", acks, 3);
    chk("b2b.txn_count", rises, 3);
    hold_if = 32'h8F0F_0E0F;

    // Slave that never acks.
    slave_en = 1'b0; rd_key = 32'h0000_1111;
    mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hf; mem_addr = 32'h2000_0000;
`ifdef ARB_TIMEOUT_EN
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      chk("to.cyc", wb_cyc, (c >= 1 && c <= 4));
      chk("to.mem_ack", mem_ack, (c == 5));
      chk("to.bus_err", bus_err, (c == 5));
      if (c == 5) chk("to.rdata_zero", mem_rdata, 32'h0);
      @(posedge clk); #1;
    end
    mem_req = 1'b0;
    @(negedge clk);
    chk("to.idle_cyc", wb_cyc, 1'b0);
    chk("to.err_once", bus_err, 1'b0);
    chk("to.ack_once", mem_ack, 1'b0);
    hold_mem = 32'h0;
    @(posedge clk); #1;
`else
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      chk("wait.bus_err", bus_err, 1'b0);
      if (c >= 1) chk("wait.cyc", wb_cyc, 1'b1);
      if (c >= 1) chk("wait.no_ack", mem_ack, 1'b0);
      @(posedge clk); #1;
    end
    force_ack = 1'b1;
    @(negedge clk);
    chk("wait.cyc_at_ack", wb_cyc, 1'b1);
    @(posedge clk); #1;
    force_ack = 1'b0;
    @(negedge clk);
    chk("wait.mem_ack", mem_ack, 1'b1);
    chk("wait.mem_rdata", mem_rdata, 32'h2000_1111);
    @(posedge clk); #1;
    mem_req = 1'b0;
    @(negedge clk);
    chk("wait.idle_cyc", wb_cyc, 1'b0);
    chk("wait.ack_once", mem_ack, 1'b0);
    hold_mem = 32'h2000_1111;
    @(posedge clk); #1;
`endif

    for (int i = 0; i < 30; i++) begin
      r.mem_req  = 1'($urandom_range(0, 1));
      r.if_req   = 1'($urandom_range(0, 1));
      if (!r.mem_req && !r.if_req) r.if_req = 1'b1;
      r.we       = 1'($urandom_range(0, 1));
      r.sel      = 4'($urandom);
      r.mem_addr = $urandom;
      r.wdata    = $urandom;
      r.if_addr  = $urandom;
      r.lat      = $urandom_range(1, 4);
      r.key      = $urandom;
      r.exp_mem  = r.mem_addr ^ r.key;
      r.exp_if   = r.if_addr ^ r.key;
      run_vec(r, $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
